// File: rtl/casper_rx_packet_filter_if.sv
// Stream bundle for casper_rx_packet_filter: the AXIS input side and the
// yellow-block output side. The filter attaches through the slave modport.
interface casper_rx_packet_filter_if #(
  parameter int unsigned DATA_WIDTH = 512
) ();
  logic [DATA_WIDTH-1:0]   axis_rx_tdata;
  logic [DATA_WIDTH/8-1:0] axis_rx_tkeep;
  logic                    axis_rx_tvalid;
  logic                    axis_rx_tlast;
  logic                    axis_rx_tuser;
  logic                    axis_rx_tready;

  logic [DATA_WIDTH-1:0]   yellow_block_rx_data;
  logic [DATA_WIDTH/8-1:0] yellow_block_rx_keep;
  logic                    yellow_block_rx_valid;
  logic                    yellow_block_rx_eof;
  logic                    yellow_block_rx_ready;

  modport slave (
    input  axis_rx_tdata, axis_rx_tkeep, axis_rx_tvalid, axis_rx_tlast, axis_rx_tuser,
    output axis_rx_tready,
    output yellow_block_rx_data, yellow_block_rx_keep, yellow_block_rx_valid,
    output yellow_block_rx_eof,
    input  yellow_block_rx_ready
  );

  modport master (
    output axis_rx_tdata, axis_rx_tkeep, axis_rx_tvalid, axis_rx_tlast, axis_rx_tuser,
    input  axis_rx_tready,
    input  yellow_block_rx_data, yellow_block_rx_keep, yellow_block_rx_valid,
    input  yellow_block_rx_eof,
    output yellow_block_rx_ready
  );
endinterface

// File: rtl/casper_rx_packet_filter.sv
// Receive packet filter: matches UDP/IPv4 destination on the first beat, stores
// packets store-and-forward, drops bad/oversize/overflowing frames, keeps stats.
module casper_rx_packet_filter #(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned FIFO_DEPTH    = 256,
  parameter int unsigned MAX_PKT_BEATS = 144,
  parameter int unsigned RATE_WINDOW   = 322265625,
  parameter bit          FILTER_EN     = 1'b1
) (
  input  logic        axis_rx_clkin,
  input  logic        Reset,
  input  logic [47:0] fabric_mac,
  input  logic [31:0] fabric_ip,
  input  logic [15:0] fabric_port,
  casper_rx_packet_filter_if.slave rx_if,
  output logic        yellow_block_rx_overrun,
  output logic [31:0] gmac_reg_rx_packet_count,
  output logic [31:0] gmac_reg_rx_valid_count,
  output logic [31:0] gmac_reg_rx_bad_packet_count,
  output logic [31:0] gmac_reg_rx_packet_rate,
  output logic [31:0] gmac_reg_rx_valid_rate,
  input  logic        gmac_reg_counters_reset
);

  localparam int unsigned KW = DATA_WIDTH / 8;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(MAX_PKT_BEATS + 1);
  localparam int unsigned WW = $clog2(RATE_WINDOW);
  localparam int unsigned EW = DATA_WIDTH + KW + 1;

  typedef enum logic [1:0] {StIdle, StPass, StDrop} state_e;

  state_e        st_q, st_d;
  logic [AW:0]   wr_q, wr_d, commit_q, commit_d, rd_q, used;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          skip_q, skip_d, overrun_q, overrun_d;
  logic          accept, last, user, we, commit_ev, space_low, hdr_match, pop;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] d;

  logic          vld_q, eof_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [KW-1:0] keep_q;

  assign d      = rx_if.axis_rx_tdata;
  assign last   = rx_if.axis_rx_tlast;
  assign user   = rx_if.axis_rx_tuser;
  assign accept = rx_if.axis_rx_tvalid & ~Reset;
  assign rx_if.axis_rx_tready = ~Reset;

  // Header fields are compared in wire order: byte 0 lands in the MSB.
  assign hdr_match = ({d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40]} == fabric_mac)
                  && ({d[103:96], d[111:104]} == 16'h0800)
                  && (d[191:184] == 8'd17)
                  && ({d[247:240], d[255:248], d[263:256], d[271:264]} == fabric_ip)
                  && ({d[295:288], d[303:296]} == fabric_port);

  assign used      = wr_q - rd_q;
  assign space_low = (FIFO_DEPTH - 32'(used)) < MAX_PKT_BEATS;

  always_comb begin
    st_d      = st_q;
    wr_d      = wr_q;
    commit_d  = commit_q;
    cnt_d     = cnt_q;
    skip_d    = skip_q;
    overrun_d = 1'b0;
    we        = 1'b0;
    commit_ev = 1'b0;
    if (accept) begin
      if (skip_q) begin
        // Tail of a packet that was cut by Reset.
        if (last) skip_d = 1'b0;
      end else begin
        unique case (st_q)
          StIdle: begin
            if (space_low) begin
              overrun_d = 1'b1;
              if (!last) st_d = StDrop;
            end else if (FILTER_EN && !hdr_match) begin
              if (!last) st_d = StDrop;
            end else begin
              we    = 1'b1;
              cnt_d = CW'(1);
              st_d  = StPass;
            end
          end
          StPass: begin
            if (cnt_q == CW'(MAX_PKT_BEATS)) begin
              wr_d = commit_q;
              st_d = last ? StIdle : StDrop;
            end else begin
              we    = 1'b1;
              cnt_d = cnt_q + CW'(1);
            end
          end
          StDrop: if (last) st_d = StIdle;
          default: st_d = StIdle;
        endcase
        if (we) begin
          wr_d = wr_q + 1'b1;
          if (last) begin
            st_d = StIdle;
            if (user) begin
              wr_d = commit_q;
            end else begin
              commit_d  = wr_q + 1'b1;
              commit_ev = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge axis_rx_clkin) begin
    if (Reset) begin
      st_q      <= StIdle;
      wr_q      <= '0;
      commit_q  <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      // Remember whether the wire is mid-packet so its tail is discarded.
      skip_q    <= rx_if.axis_rx_tvalid ? ~last : (skip_q | (st_q != StIdle));
    end else begin
      st_q      <= st_d;
      wr_q      <= wr_d;
      commit_q  <= commit_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      skip_q    <= skip_d;
    end
  end

  always_ff @(posedge axis_rx_clkin) begin
    if (we) mem[wr_q[AW-1:0]] <= {last, rx_if.axis_rx_tkeep, d};
  end

  assign pop = (rd_q != commit_q) && (!vld_q || rx_if.yellow_block_rx_ready);

  always_ff @(posedge axis_rx_clkin) begin
    if (Reset) begin
      rd_q   <= '0;
      vld_q  <= 1'b0;
      eof_q  <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
    end else if (pop) begin
      {eof_q, keep_q, data_q} <= mem[rd_q[AW-1:0]];
      vld_q <= 1'b1;
      rd_q  <= rd_q + 1'b1;
    end else if (rx_if.yellow_block_rx_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign rx_if.yellow_block_rx_data  = data_q;
  assign rx_if.yellow_block_rx_keep  = keep_q;
  assign rx_if.yellow_block_rx_valid = vld_q;
  assign rx_if.yellow_block_rx_eof   = eof_q;
  assign yellow_block_rx_overrun     = overrun_q;

  logic          ev_pkt, ev_bad, win_wrap;
  logic [WW-1:0] win_q;
  logic [31:0]   pkt_cnt_q, val_cnt_q, bad_cnt_q, win_pkt_q, win_val_q, pkt_rate_q, val_rate_q;

  assign ev_pkt   = accept & last;
  assign ev_bad   = ev_pkt & user;
  assign win_wrap = (win_q == WW'(RATE_WINDOW - 1));

  always_ff @(posedge axis_rx_clkin) begin
    if (Reset || gmac_reg_counters_reset) begin
      win_q      <= '0;
      pkt_cnt_q  <= '0;
      val_cnt_q  <= '0;
      bad_cnt_q  <= '0;
      win_pkt_q  <= '0;
      win_val_q  <= '0;
      pkt_rate_q <= '0;
      val_rate_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_q + 32'(ev_pkt);
      val_cnt_q <= val_cnt_q + 32'(commit_ev);
      bad_cnt_q <= bad_cnt_q + 32'(ev_bad);
      if (win_wrap) begin
        // A wrap-cycle event closes out the finished window.
        win_q      <= '0;
        pkt_rate_q <= win_pkt_q + 32'(ev_pkt);
        val_rate_q <= win_val_q + 32'(commit_ev);
        win_pkt_q  <= '0;
        win_val_q  <= '0;
      end else begin
        win_q     <= win_q + WW'(1);
        win_pkt_q <= win_pkt_q + 32'(ev_pkt);
        win_val_q <= win_val_q + 32'(commit_ev);
      end
    end
  end

  assign gmac_reg_rx_packet_count     = pkt_cnt_q;
  assign gmac_reg_rx_valid_count      = val_cnt_q;
  assign gmac_reg_rx_bad_packet_count = bad_cnt_q;
  assign gmac_reg_rx_packet_rate      = pkt_rate_q;
  assign gmac_reg_rx_valid_rate       = val_rate_q;

endmodule

// File: tb/tb_casper_rx_packet_filter.sv
// Directed bench for casper_rx_packet_filter: filtering, bad frames, overrun,
// rate windows and mid-packet reset.
module tb_casper_rx_packet_filter;
  localparam int unsigned DW = 512;
  localparam logic [47:0] FMAC = 48'h02_11_22_33_44_55;
  localparam logic [31:0] FIP  = 32'h0a_00_00_07;
  localparam logic [15:0] FPRT = 16'h1234;

  logic clk = 1'b0;
  logic rst;
  logic ctr_rst;
  logic overrun;
  logic [31:0] pkt_cnt, val_cnt, bad_cnt, pkt_rate, val_rate;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_cyc = 0;
  int ovr_cnt  = 0;
  logic [32:0] out_q[$];
  int out_cyc[$];

  casper_rx_packet_filter_if #(.DATA_WIDTH(DW)) bus ();

  casper_rx_packet_filter #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(256), .MAX_PKT_BEATS(144), .RATE_WINDOW(100), .FILTER_EN(1'b1)
  ) dut (
    .axis_rx_clkin(clk), .Reset(rst), .fabric_mac(FMAC), .fabric_ip(FIP),
    .fabric_port(FPRT), .rx_if(bus), .yellow_block_rx_overrun(overrun),
    .gmac_reg_rx_packet_count(pkt_cnt), .gmac_reg_rx_valid_count(val_cnt),
    .gmac_reg_rx_bad_packet_count(bad_cnt), .gmac_reg_rx_packet_rate(pkt_rate),
    .gmac_reg_rx_valid_rate(val_rate), .gmac_reg_counters_reset(ctr_rst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.yellow_block_rx_valid && bus.yellow_block_rx_ready) begin
      out_q.push_back({bus.yellow_block_rx_eof, bus.yellow_block_rx_data[511:480]});
      out_cyc.push_back(cyc);
    end
    if (overrun) ovr_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] make_hdr(input logic [15:0] port);
    logic [511:0] d;
    logic [47:0] mac;
    logic [31:0] ip;
    d   = '0;
    mac = FMAC;
    ip  = FIP;
    for (int i = 0; i < 6; i++) d[8*i +: 8] = mac[8*(5-i) +: 8];
    d[8*12 +: 8] = 8'h08;
    d[8*13 +: 8] = 8'h00;
    d[8*23 +: 8] = 8'd17;
    for (int i = 0; i < 4; i++) d[8*(30+i) +: 8] = ip[8*(3-i) +: 8];
    d[8*36 +: 8] = port[15:8];
    d[8*37 +: 8] = port[7:0];
    return d;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.axis_rx_tvalid = 1'b0;
    bus.axis_rx_tlast  = 1'b0;
    bus.axis_rx_tuser  = 1'b0;
    tick(n);
  endtask

  task automatic beat(input logic [15:0] port, input logic [15:0] tag, input int b,
                      input logic last, input logic user);
    logic [511:0] d;
    d = (b == 0) ? make_hdr(port) : {16{32'hc0de_0000 | b}};
    d[511:496] = tag;
    d[495:480] = 16'(b);
    bus.axis_rx_tdata  = d;
    bus.axis_rx_tkeep  = '1;
    bus.axis_rx_tvalid = 1'b1;
    bus.axis_rx_tlast  = last;
    bus.axis_rx_tuser  = user;
    if (last) last_cyc = cyc;
    tick(1);
  endtask

  task automatic send_pkt(input int n, input logic [15:0] port, input logic user,
                          input logic [15:0] tag);
    for (int b = 0; b < n; b++) beat(port, tag, b, b == n - 1, user && (b == n - 1));
  endtask

  task automatic clr_stats();
    ctr_rst = 1'b1;
    tick(1);
    ctr_rst = 1'b0;
    out_q.delete();
    out_cyc.delete();
    ovr_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_checks += 6;
    if (bus.axis_rx_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b want 0", bus.axis_rx_tready); end
    if (bus.yellow_block_rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.yellow_block_rx_valid); end
    if (bus.yellow_block_rx_eof !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL rst_eof_ovr: got %b%b want 00", bus.yellow_block_rx_eof, overrun); end
    if (bus.yellow_block_rx_data !== '0 || bus.yellow_block_rx_keep !== '0) begin n_fail++; $display("FAIL rst_data: got nonzero data/keep want 0"); end
    if (pkt_cnt !== 0 || val_cnt !== 0 || bad_cnt !== 0) begin n_fail++; $display("FAIL rst_counts: got %0d/%0d/%0d want 0/0/0", pkt_cnt, val_cnt, bad_cnt); end
    if (pkt_rate !== 0 || val_rate !== 0) begin n_fail++; $display("FAIL rst_rates: got %0d/%0d want 0/0", pkt_rate, val_rate); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.axis_rx_tready !== 1'b1) begin n_fail++; $display("FAIL run_tready: got %b want 1", bus.axis_rx_tready); end
    tick(1);
  endtask

  task automatic test_match();
    logic [32:0] got, exp;
    clr_stats();
    send_pkt(3, FPRT, 1'b0, 16'd1);
    idle(8);
    n_checks++;
    if (out_q.size() != 3) begin n_fail++; $display("FAIL match_beats: got %0d want 3", out_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < out_q.size()) ? out_q[i] : '1;
      exp = {i == 2, 16'd1, 16'(i)};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL match_beat%0d: got %h want %h", i, got, exp); end
    end
    n_checks += 3;
    if (out_cyc.size() == 0 || out_cyc[0] != last_cyc + 2) begin
      n_fail++; $display("FAIL match_latency: got %0d want %0d", out_cyc.size() ? out_cyc[0] : -1, last_cyc + 2);
    end
    if (val_cnt !== 32'd1) begin n_fail++; $display("FAIL match_valid_cnt: got %0d want 1", val_cnt); end
    if (pkt_cnt !== 32'd1) begin n_fail++; $display("FAIL match_pkt_cnt: got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_filter();
    clr_stats();
    send_pkt(2, 16'h1235, 1'b0, 16'd2);
    idle(8);
    n_checks += 3;
    if (out_q.size() != 0) begin n_fail++; $display("FAIL filter_beats: got %0d want 0", out_q.size()); end
    if (pkt_cnt !== 32'd1) begin n_fail++; $display("FAIL filter_pkt_cnt: got %0d want 1", pkt_cnt); end
    if (val_cnt !== 32'd0) begin n_fail++; $display("FAIL filter_valid_cnt: got %0d want 0", val_cnt); end
  endtask

  task automatic test_bad();
    logic [32:0] got, exp;
    clr_stats();
    send_pkt(4, FPRT, 1'b1, 16'd3);
    send_pkt(2, FPRT, 1'b0, 16'd4);
    idle(8);
    n_checks += 3;
    if (out_q.size() != 2) begin n_fail++; $display("FAIL bad_beats: got %0d want 2", out_q.size()); end
    if (bad_cnt !== 32'd1) begin n_fail++; $display("FAIL bad_cnt: got %0d want 1", bad_cnt); end
    if (pkt_cnt !== 32'd2 || val_cnt !== 32'd1) begin n_fail++; $display("FAIL bad_counts: got %0d/%0d want 2/1", pkt_cnt, val_cnt); end
    for (int i = 0; i < 2; i++) begin
      got = (i < out_q.size()) ? out_q[i] : '1;
      exp = {i == 1, 16'd4, 16'(i)};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL bad_next_beat%0d: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_overrun();
    int bad_beats;
    logic [32:0] exp;
    bus.yellow_block_rx_ready = 1'b0;
    clr_stats();
    send_pkt(144, FPRT, 1'b0, 16'd5);
    send_pkt(144, FPRT, 1'b0, 16'd6);
    send_pkt(144, FPRT, 1'b0, 16'd7);
    idle(4);
    n_checks += 3;
    if (ovr_cnt != 2) begin n_fail++; $display("FAIL ovr_pulses: got %0d want 2", ovr_cnt); end
    if (out_q.size() != 0) begin n_fail++; $display("FAIL ovr_held: got %0d want 0", out_q.size()); end
    if (pkt_cnt !== 32'd3 || val_cnt !== 32'd1) begin n_fail++; $display("FAIL ovr_counts: got %0d/%0d want 3/1", pkt_cnt, val_cnt); end
    bus.yellow_block_rx_ready = 1'b1;
    idle(160);
    bad_beats = 0;
    for (int i = 0; i < out_q.size(); i++) begin
      exp = {i == 143, 16'd5, 16'(i)};
      if (out_q[i] !== exp) bad_beats++;
    end
    n_checks += 2;
    if (out_q.size() != 144) begin n_fail++; $display("FAIL ovr_drain_beats: got %0d want 144", out_q.size()); end
    if (bad_beats != 0) begin n_fail++; $display("FAIL ovr_drain_content: got %0d wrong beats want 0", bad_beats); end
  endtask

  task automatic test_rate();
    bus.yellow_block_rx_ready = 1'b1;
    clr_stats();
    for (int k = 0; k < 25; k++) begin
      send_pkt(1, FPRT, 1'b0, 16'd20);
      idle(9);
    end
    n_checks += 2;
    if (pkt_rate !== 32'd10) begin n_fail++; $display("FAIL rate_pkt_w2: got %0d want 10", pkt_rate); end
    if (val_rate !== 32'd10) begin n_fail++; $display("FAIL rate_valid_w2: got %0d want 10", val_rate); end
    for (int k = 0; k < 10; k++) begin
      send_pkt(1, FPRT, 1'b0, 16'd21);
      idle(9);
    end
    n_checks += 3;
    if (pkt_rate !== 32'd10) begin n_fail++; $display("FAIL rate_pkt_w3: got %0d want 10", pkt_rate); end
    if (val_rate !== 32'd10) begin n_fail++; $display("FAIL rate_valid_w3: got %0d want 10", val_rate); end
    if (pkt_cnt !== 32'd35) begin n_fail++; $display("FAIL rate_pkt_cnt: got %0d want 35", pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [32:0] got, exp;
    bus.yellow_block_rx_ready = 1'b0;
    clr_stats();
    send_pkt(1, FPRT, 1'b0, 16'd11);
    beat(FPRT, 16'd9, 0, 1'b0, 1'b0);
    beat(FPRT, 16'd9, 1, 1'b0, 1'b0);
    bus.axis_rx_tvalid = 1'b0;
    rst = 1'b1;
    tick(2);
    n_checks += 3;
    if (bus.yellow_block_rx_valid !== 1'b0 || bus.yellow_block_rx_eof !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_valid: got %b%b want 00", bus.yellow_block_rx_valid, bus.yellow_block_rx_eof);
    end
    if (bus.yellow_block_rx_data !== '0 || bus.axis_rx_tready !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_data: got data/tready nonzero want 0");
    end
    if (pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d want 0", pkt_cnt); end
    rst = 1'b0;
    bus.yellow_block_rx_ready = 1'b1;
    for (int b = 2; b < 6; b++) beat(FPRT, 16'd9, b, b == 5, 1'b0);
    send_pkt(2, FPRT, 1'b0, 16'd10);
    idle(8);
    n_checks += 2;
    if (out_q.size() != 2) begin n_fail++; $display("FAIL mid_beats: got %0d want 2", out_q.size()); end
    if (pkt_cnt !== 32'd2 || val_cnt !== 32'd1) begin n_fail++; $display("FAIL mid_counts: got %0d/%0d want 2/1", pkt_cnt, val_cnt); end
    for (int i = 0; i < 2; i++) begin
      got = (i < out_q.size()) ? out_q[i] : '1;
      exp = {i == 1, 16'd10, 16'(i)};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL mid_beat%0d: got %h want %h", i, got, exp); end
    end
  endtask

  initial begin
    rst = 1'b1;
    ctr_rst = 1'b0;
    bus.axis_rx_tdata = '0;
    bus.axis_rx_tkeep = '0;
    bus.axis_rx_tvalid = 1'b0;
    bus.axis_rx_tlast = 1'b0;
    bus.axis_rx_tuser = 1'b0;
    bus.yellow_block_rx_ready = 1'b1;
    tick(1);
    test_reset();
    test_match();
    test_filter();
    test_bad();
    test_overrun();
    test_rate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
